pipe_stage_buf: RTL and testbench

// - Parametrised successor of the fixed IF/ID latch: generic elastic pipeline stage register

---
 rtl/pipe_stage_buf_if.sv | 26 ++
 rtl/pipe_stage_buf.sv | 125 ++++++++++++
 tb/tb_pipe_stage_buf.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_buf_if.sv
// Handshake/payload bundle for one elastic pipeline stage: upstream push side,
// downstream pop side and the stage-wide start/flush controls.
interface pipe_stage_buf_if #(
    parameter int DATA_W = 64
);
    logic              start_i;
    logic              flush_i;
    logic              valid_i;
    logic              ready_o;
    logic [DATA_W-1:0] data_i;
    logic              valid_o;
    logic              ready_i;
    logic [DATA_W-1:0] data_o;

    // Stage side: consumes upstream beats and the controls, produces downstream beats.
    modport slave (
        input  start_i, flush_i, valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o
    );

    // Environment side: the neighbouring stages and the pipeline controller.
    modport master (
        output start_i, flush_i, valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o
    );
endinterface

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage register with a 2-entry skid buffer, valid/ready on both sides,
// synchronous flush to FLUSH_VAL. Optional stall/flush statistics under `PIPE_STATS_EN.
module pipe_stage_buf #(
    parameter int                 DATA_W    = 64,
    parameter logic [DATA_W-1:0]  FLUSH_VAL = '0,
    parameter int                 CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_i,
    pipe_stage_buf_if.slave   bus,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] main_q,  main_d;
    logic [DATA_W-1:0] skid_q,  skid_d;

    logic ready_w;
    logic valid_w;
    logic push;
    logic pop;

    // Outputs depend only on registered state plus start/reset, never on ready_i or data_i.
    assign ready_w = bus.start_i & ~rst_i & (state_q != ST_SKID);
    assign valid_w = bus.start_i & ~rst_i & (state_q != ST_EMPTY);
    assign push    = bus.valid_i & ready_w;
    assign pop     = valid_w & bus.ready_i;

    assign bus.ready_o = ready_w;
    assign bus.valid_o = valid_w;
    assign bus.data_o  = main_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (bus.start_i) begin
            if (bus.flush_i) begin
                // The pop presented this cycle still completes; the push is dropped.
                state_d = ST_EMPTY;
                main_d  = FLUSH_VAL;
                skid_d  = FLUSH_VAL;
            end else begin
                case (state_q)
                    ST_EMPTY: begin
                        if (push) begin
                            state_d = ST_FULL;
                            main_d  = bus.data_i;
                        end
                    end
                    ST_FULL: begin
                        if (push && pop) begin
                            main_d  = bus.data_i;
                        end else if (push) begin
                            state_d = ST_SKID;
                            skid_d  = bus.data_i;
                        end else if (pop) begin
                            state_d = ST_EMPTY;
                        end
                    end
                    ST_SKID: begin
                        if (pop) begin
                            state_d = ST_FULL;
                            main_d  = skid_q;
                        end
                    end
                    default: begin
                        state_d = ST_EMPTY;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
            main_q  <= FLUSH_VAL;
            skid_q  <= FLUSH_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef PIPE_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating counters; valid_w already folds in start_i so both freeze while stopped.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (valid_w && !bus.ready_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (bus.start_i && bus.flush_i && (state_q != ST_EMPTY)
            && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Table-driven bench for pipe_stage_buf: per-cycle handshake expectations plus a
// scoreboard queue that checks FIFO order of every popped beat.
module tb_pipe_stage_buf;
    localparam int              DW = 16;
    localparam int              CW = 3;
    localparam logic [DW-1:0]   FV = 16'h5A5A;

    typedef struct {
        logic          rst;
        logic          st;
        logic          v;
        logic [DW-1:0] d;
        logic          fl;
        logic          rdy;
        logic          ev;
        logic          er;
        logic          chk;
        logic [DW-1:0] ed;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;

    pipe_stage_buf_if #(.DATA_W(DW)) bus ();

    pipe_stage_buf #(
        .DATA_W    (DW),
        .FLUSH_VAL (FV),
        .CNT_W     (CW)
    ) dut (
        .clk         (clk),
        .rst_i       (rst),
        .bus         (bus),
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] sb_q[$];
    vec_t tbl[32];

    function automatic vec_t mk(logic r, logic s, logic v, logic [DW-1:0] d, logic f,
                                logic rd, logic ev, logic er, logic c, logic [DW-1:0] ed);
        vec_t t;
        t.rst = r; t.st = s; t.v = v; t.d = d; t.fl = f; t.rdy = rd;
        t.ev = ev; t.er = er; t.chk = c; t.ed = ed;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h, want %h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input int idx);
        logic [DW-1:0] exp_beat;
        rst         = t.rst;
        bus.start_i = t.st;
        bus.valid_i = t.v;
        bus.data_i  = t.d;
        bus.flush_i = t.fl;
        bus.ready_i = t.rdy;
        @(negedge clk);
        chk("valid_o", idx, {31'd0, bus.valid_o}, {31'd0, t.ev});
        chk("ready_o", idx, {31'd0, bus.ready_o}, {31'd0, t.er});
        if (t.chk) chk("data_o", idx, {16'd0, bus.data_o}, {16'd0, t.ed});
        if (t.ev && t.rdy) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", idx, 32'd1, 32'd0);
            end else begin
                exp_beat = sb_q.pop_front();
                chk("sb_beat", idx, {16'd0, bus.data_o}, {16'd0, exp_beat});
                $display("row %0d: popped %h (expected %h)", idx, bus.data_o, exp_beat);
            end
        end
        if (t.rst || (t.st && t.fl)) sb_q.delete();
        if (t.v && t.er && !t.fl && !t.rst) sb_q.push_back(t.d);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [CW-1:0] exp_stall5, exp_stall_sat, exp_flush1;
        int row;
        //              rst st v  d        fl rdy ev er chk ed
        tbl[0]  = mk(1, 1, 0, 16'h0000, 0, 1, 0, 0, 0, 16'h0000);
        tbl[1]  = mk(1, 1, 0, 16'h0000, 0, 1, 0, 0, 1, FV);
        tbl[2]  = mk(0, 1, 0, 16'h0000, 0, 1, 0, 1, 1, FV);
        tbl[3]  = mk(0, 1, 1, 16'h000A, 0, 1, 0, 1, 1, FV);
        tbl[4]  = mk(0, 1, 1, 16'h000B, 0, 1, 1, 1, 1, 16'h000A);
        tbl[5]  = mk(0, 1, 1, 16'h000C, 0, 1, 1, 1, 1, 16'h000B);
        tbl[6]  = mk(0, 1, 0, 16'h0000, 0, 1, 1, 1, 1, 16'h000C);
        tbl[7]  = mk(0, 1, 0, 16'h0000, 0, 1, 0, 1, 1, 16'h000C);
        tbl[8]  = mk(0, 1, 1, 16'h000A, 0, 0, 0, 1, 1, 16'h000C);
        tbl[9]  = mk(0, 1, 1, 16'h000B, 0, 0, 1, 1, 1, 16'h000A);
        tbl[10] = mk(0, 1, 1, 16'h000E, 0, 0, 1, 0, 1, 16'h000A);
        tbl[11] = mk(0, 1, 0, 16'h0000, 0, 1, 1, 0, 1, 16'h000A);
        tbl[12] = mk(0, 1, 0, 16'h0000, 0, 1, 1, 1, 1, 16'h000B);
        tbl[13] = mk(0, 1, 0, 16'h0000, 0, 1, 0, 1, 1, 16'h000B);
        tbl[14] = mk(0, 1, 1, 16'h0001, 0, 0, 0, 1, 1, 16'h000B);
        tbl[15] = mk(0, 1, 1, 16'h0002, 0, 0, 1, 1, 1, 16'h0001);
        tbl[16] = mk(0, 1, 1, 16'h000D, 1, 0, 1, 0, 1, 16'h0001);
        tbl[17] = mk(0, 1, 0, 16'h0000, 0, 1, 0, 1, 1, FV);
        tbl[18] = mk(0, 1, 1, 16'h0003, 0, 1, 0, 1, 1, FV);
        tbl[19] = mk(0, 1, 1, 16'h0004, 1, 1, 1, 1, 1, 16'h0003);
        tbl[20] = mk(0, 1, 0, 16'h0000, 0, 1, 0, 1, 1, FV);
        tbl[21] = mk(0, 1, 1, 16'h000A, 0, 0, 0, 1, 1, FV);
        tbl[22] = mk(0, 0, 1, 16'h000F, 1, 1, 0, 0, 1, 16'h000A);
        tbl[23] = mk(0, 0, 1, 16'h000F, 1, 1, 0, 0, 1, 16'h000A);
        tbl[24] = mk(0, 0, 1, 16'h000F, 1, 1, 0, 0, 1, 16'h000A);
        tbl[25] = mk(0, 1, 1, 16'h000B, 0, 1, 1, 1, 1, 16'h000A);
        tbl[26] = mk(0, 1, 0, 16'h0000, 0, 1, 1, 1, 1, 16'h000B);
        tbl[27] = mk(0, 1, 0, 16'h0000, 0, 1, 0, 1, 1, 16'h000B);
        tbl[28] = mk(0, 1, 1, 16'h000C, 0, 0, 0, 1, 1, 16'h000B);
        tbl[29] = mk(0, 1, 1, 16'h000D, 0, 0, 1, 1, 1, 16'h000C);
        tbl[30] = mk(1, 1, 1, 16'h0000, 0, 1, 0, 0, 1, 16'h000C);
        tbl[31] = mk(0, 1, 0, 16'h0000, 0, 1, 0, 1, 1, FV);

`ifdef PIPE_STATS_EN
        exp_stall5    = 3'd5;
        exp_stall_sat = 3'd7;
        exp_flush1    = 3'd1;
`else
        exp_stall5    = 3'd0;
        exp_stall_sat = 3'd0;
        exp_flush1    = 3'd0;
`endif

        rst = 1'b1;
        bus.start_i = 1'b1; bus.valid_i = 1'b0; bus.data_i = '0;
        bus.flush_i = 1'b0; bus.ready_i = 1'b0;

        for (int i = 0; i < 32; i++) apply(tbl[i], i);

        // Counter saturation and flush counting from a clean reset.
        row = 100;
        apply(mk(1, 1, 0, 16'h0000, 0, 0, 0, 0, 1, FV), row++);
        chk("stall_cnt_rst", row, {29'd0, stall_cnt}, 32'd0);
        chk("flush_cnt_rst", row, {29'd0, flush_cnt}, 32'd0);
        apply(mk(0, 1, 1, 16'h0007, 0, 0, 0, 1, 1, FV), row++);
        for (int i = 0; i < 5; i++) apply(mk(0, 1, 0, 16'h0000, 0, 0, 1, 1, 1, 16'h0007), row++);
        chk("stall_cnt_5", row, {29'd0, stall_cnt}, {29'd0, exp_stall5});
        for (int i = 0; i < 5; i++) apply(mk(0, 1, 0, 16'h0000, 0, 0, 1, 1, 1, 16'h0007), row++);
        chk("stall_cnt_sat", row, {29'd0, stall_cnt}, {29'd0, exp_stall_sat});
        apply(mk(0, 1, 0, 16'h0000, 1, 0, 1, 1, 1, 16'h0007), row++);
        chk("flush_cnt_full", row, {29'd0, flush_cnt}, {29'd0, exp_flush1});
        chk("stall_cnt_hold", row, {29'd0, stall_cnt}, {29'd0, exp_stall_sat});
        apply(mk(0, 1, 0, 16'h0000, 1, 1, 0, 1, 1, FV), row++);
        chk("flush_cnt_empty", row, {29'd0, flush_cnt}, {29'd0, exp_flush1});
        apply(mk(1, 1, 0, 16'h0000, 0, 1, 0, 0, 1, FV), row++);
        chk("stall_cnt_clr", row, {29'd0, stall_cnt}, 32'd0);
        chk("flush_cnt_clr", row, {29'd0, flush_cnt}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
